// File: rtl/snes_pad_emulator.sv
// snes_pad_emulator: device-side SNES pad; shifts a 16-bit button word out on host latch/clock (optional SNES_PAD_DEGLITCH_EN input filter)
module snes_pad_emulator #(
  parameter int CLOCK_FREQ_HZ = 25000000,
  parameter int TIMEOUT_US = 1000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        snes_latch_in,
  input  logic        snes_clock_in,
  input  logic [15:0] buttons,
  output logic        snes_data,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout
);
  localparam int TO_CYCLES = CLOCK_FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int TW = $clog2(TO_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, TAIL} state_t;
  state_t state;
  logic [1:0] latch_s, clk_s;
  logic latch_v, clk_v, latch_d, clk_d;
  logic [15:0] shreg;
  logic [4:0] bit_cnt;
  logic [TW-1:0] tcnt;
  // two-flop synchronizers; host clock idles high, latch idles low
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      latch_s <= 2'b00;
      clk_s <= 2'b11;
    end else begin
      latch_s <= {latch_s[0], snes_latch_in};
      clk_s <= {clk_s[0], snes_clock_in};
    end
`ifdef SNES_PAD_DEGLITCH_EN
  logic latch_h, clk_h, latch_f, clk_f;
  // accept a new level only once three consecutive samples along the chain agree
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      latch_h <= 1'b0;
      clk_h <= 1'b1;
      latch_f <= 1'b0;
      clk_f <= 1'b1;
    end else begin
      latch_h <= latch_s[1];
      clk_h <= clk_s[1];
      if (latch_s[0] == latch_s[1] && latch_s[1] == latch_h) latch_f <= latch_s[1];
      if (clk_s[0] == clk_s[1] && clk_s[1] == clk_h) clk_f <= clk_s[1];
    end
  assign latch_v = latch_f;
  assign clk_v = clk_f;
`else
  assign latch_v = latch_s[1];
  assign clk_v = clk_s[1];
`endif
  // one-cycle-delayed copies for edge detection
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      latch_d <= 1'b0;
      clk_d <= 1'b1;
    end else begin
      latch_d <= latch_v;
      clk_d <= clk_v;
    end
  wire latch_rise = latch_v & ~latch_d;
  wire latch_fall = ~latch_v & latch_d;
  wire clock_rise = clk_v & ~clk_d;
  assign busy = state != IDLE;
  // protocol FSM; a latch rise preempts everything, including a same-cycle clock rise
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      shreg <= 16'hFFFF;
      bit_cnt <= 5'd0;
      tcnt <= '0;
      snes_data <= 1'b1;
      frame_done <= 1'b0;
      timeout <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      timeout <= 1'b0;
      if (latch_rise) begin
        state <= LATCH;
        shreg <= buttons;
        snes_data <= buttons[0];
      end else begin
        case (state)
          IDLE: snes_data <= 1'b1;
          LATCH:
            if (latch_fall) begin
              state <= SHIFT;
              bit_cnt <= 5'd0;
              tcnt <= '0;
            end else begin
              shreg <= buttons;
              snes_data <= buttons[0];
            end
          SHIFT:
            if (clock_rise) begin
              shreg <= {1'b1, shreg[15:1]};
              bit_cnt <= bit_cnt + 5'd1;
              tcnt <= '0;
              if (bit_cnt == 5'd15) begin
                frame_done <= 1'b1;
                state <= TAIL;
                snes_data <= 1'b0;
              end else begin
                snes_data <= shreg[1];
              end
            end else if (tcnt == TO_LAST) begin
              timeout <= 1'b1;
              state <= IDLE;
              snes_data <= 1'b1;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          default: snes_data <= 1'b0;
        endcase
      end
    end
endmodule
